// File: rtl/wb_pwm_bank.sv
// Purpose: bank of CHANNELS PWM generators behind a Wishbone slave, each channel drives one pad and its OE.
// Latency: register accesses are acked one cycle after the request; pwm_o/pwm_oeb/irq_o are registered (1 cycle).
// Backpressure: none; every decode hit is acked after one cycle, so back-to-back requests ack every other cycle.
// Ports: wb_clk_i/wb_rst_ni clock and sync active-low reset; wbs_* Wishbone slave (byte address, byte enables);
//        pwm_o/pwm_oeb per-channel pad output and active-low enable; irq_o OR of enabled per-channel WRAP flags.
module wb_pwm_bank #(
    parameter int unsigned CHANNELS  = 8,
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [CHANNELS-1:0] pwm_o,
    output logic [CHANNELS-1:0] pwm_oeb,
    output logic                irq_o
);
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_DUTY   = 2'd2;

    // Control and status, one bit per channel
    logic [CHANNELS-1:0] en, pol, irq_en, wrap;
    // Programmed (bus-visible) and active (counter-facing) period/duty
    logic [CNT_W-1:0] period_prog [CHANNELS];
    logic [CNT_W-1:0] duty_prog   [CHANNELS];
    logic [CNT_W-1:0] period_act  [CHANNELS];
    logic [CNT_W-1:0] duty_act    [CHANNELS];
    logic [CNT_W-1:0] cnt         [CHANNELS];

    // Values the bus write of this cycle will leave in the registers
    logic [CHANNELS-1:0] en_nxt, pol_nxt, irq_en_nxt, wrap_clr;
    logic [CNT_W-1:0] period_nxt [CHANNELS];
    logic [CNT_W-1:0] duty_nxt   [CHANNELS];

    logic        hit, req, wr;
    logic [7:0]  adr_ch;
    logic [1:0]  adr_reg;
    logic [31:0] wmask, rdata, cnt_ext;
    logic        unused;

    assign hit     = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    // Holding off while ack is high makes a held strobe produce one access per two cycles
    assign req     = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
    assign wr      = req & wbs_we_i;
    assign adr_ch  = wbs_adr_i[11:4];
    assign adr_reg = wbs_adr_i[3:2];
    assign wmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign unused  = ^{wbs_adr_i[1:0], wbs_dat_i, wmask, cnt_ext};

    // Write decode; channel indices past CHANNELS-1 match no loop iteration and are ignored
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            en_nxt[i]     = en[i];
            pol_nxt[i]    = pol[i];
            irq_en_nxt[i] = irq_en[i];
            period_nxt[i] = period_prog[i];
            duty_nxt[i]   = duty_prog[i];
            wrap_clr[i]   = 1'b0;
            if (wr && ({24'd0, adr_ch} == i)) begin
                case (adr_reg)
                    REG_CTRL: begin
                        if (wbs_sel_i[0]) begin
                            en_nxt[i]     = wbs_dat_i[0];
                            pol_nxt[i]    = wbs_dat_i[1];
                            irq_en_nxt[i] = wbs_dat_i[2];
                        end
                    end
                    REG_PERIOD: period_nxt[i] = (period_prog[i] & ~wmask[CNT_W-1:0])
                                              | (wbs_dat_i[CNT_W-1:0] & wmask[CNT_W-1:0]);
                    REG_DUTY:   duty_nxt[i]   = (duty_prog[i] & ~wmask[CNT_W-1:0])
                                              | (wbs_dat_i[CNT_W-1:0] & wmask[CNT_W-1:0]);
                    default:    wrap_clr[i]   = wbs_sel_i[0] & wbs_dat_i[0];
                endcase
            end
        end
    end

    // Read mux; unmapped channels fall through to zero
    always_comb begin
        rdata   = '0;
        cnt_ext = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if ({24'd0, adr_ch} == i) begin
                cnt_ext = 32'(cnt[i]);
                case (adr_reg)
                    REG_CTRL:   rdata = {29'd0, irq_en[i], pol[i], en[i]};
                    REG_PERIOD: rdata = 32'(period_prog[i]);
                    REG_DUTY:   rdata = 32'(duty_prog[i]);
                    default:    rdata = {((CNT_W <= 16) ? cnt_ext[15:0] : 16'd0), 15'd0, wrap[i]};
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            irq_o     <= 1'b0;
            en        <= '0;
            pol       <= '0;
            irq_en    <= '0;
            wrap      <= '0;
            pwm_o     <= '0;
            pwm_oeb   <= '1;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                period_prog[i] <= '0;
                duty_prog[i]   <= '0;
                period_act[i]  <= '0;
                duty_act[i]    <= '0;
                cnt[i]         <= '0;
            end
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'd0;
            irq_o     <= |(wrap & irq_en);
            en        <= en_nxt;
            pol       <= pol_nxt;
            irq_en    <= irq_en_nxt;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                period_prog[i] <= period_nxt[i];
                duty_prog[i]   <= duty_nxt[i];
                pwm_o[i]       <= en[i] ? ((cnt[i] < duty_act[i]) ^ pol[i]) : pol[i];
                pwm_oeb[i]     <= ~en[i];
                // A disabling write stops the counter on its own edge; enabling only
                // takes effect from the following edge so counting starts at 0.
                if (!(en[i] && en_nxt[i])) begin
                    cnt[i]        <= '0;
                    period_act[i] <= period_prog[i];
                    duty_act[i]   <= duty_prog[i];
                    wrap[i]       <= wrap[i] & ~wrap_clr[i];
                end else if (cnt[i] == period_act[i]) begin
                    // Wrap edge: shadows load and WRAP is set, overriding a coincident clear
                    cnt[i]        <= '0;
                    period_act[i] <= period_prog[i];
                    duty_act[i]   <= duty_prog[i];
                    wrap[i]       <= 1'b1;
                end else begin
                    cnt[i]        <= cnt[i] + CNT_W'(1);
                    wrap[i]       <= wrap[i] & ~wrap_clr[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_pwm_bank.sv
module tb_wb_pwm_bank;
    localparam int NCH = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, dat = 32'h0;
    logic        wbs_ack_o, irq_o;
    logic [31:0] wbs_dat_o;
    logic [NCH-1:0] pwm_o, pwm_oeb;

    wb_pwm_bank dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .pwm_o(pwm_o), .pwm_oeb(pwm_oeb), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit rd; logic [31:0] d; } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    bit          m_en[NCH], m_pol[NCH], m_ie[NCH], m_wrap[NCH];
    int unsigned m_per[NCH], m_duty[NCH], m_pa[NCH], m_da[NCH], m_cnt[NCH];
    logic [NCH-1:0] e_pwm = '0, e_oeb = '1;
    bit          e_irq = 1'b0, m_ack = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int ch, input int rg);
        logic [31:0] v;
        v = 32'h0;
        if (ch < NCH) begin
            case (rg)
                0: v = {29'd0, m_ie[ch], m_pol[ch], m_en[ch]};
                1: v = m_per[ch];
                2: v = m_duty[ch];
                default: v = (m_cnt[ch] << 16) | 32'(m_wrap[ch]);
            endcase
        end
        return v;
    endfunction

    // One clock of the peripheral as the register map describes it: a channel's
    // phase runs 0..period, a finished period reloads the programmed values.
    task automatic model_step();
        bit req, wr, hit_c, en_after, clr;
        int ch, rg;
        logic [31:0] v;
        sb_t t;
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_en[c] = 0; m_pol[c] = 0; m_ie[c] = 0; m_wrap[c] = 0;
                m_per[c] = 0; m_duty[c] = 0; m_pa[c] = 0; m_da[c] = 0; m_cnt[c] = 0;
            end
            e_pwm = '0; e_oeb = '1; e_irq = 0; m_ack = 0;
        end else begin
            e_irq = 0;
            for (int c = 0; c < NCH; c++) begin
                e_pwm[c] = m_en[c] ? (m_pol[c] ^ (m_cnt[c] < m_da[c])) : m_pol[c];
                e_oeb[c] = !m_en[c];
                if (m_wrap[c] && m_ie[c]) e_irq = 1;
            end
            req = cyc && stb && (adr[31:12] == 20'h30000) && !m_ack;
            ch  = int'(adr[11:4]);
            rg  = int'(adr[3:2]);
            wr  = req && we && (ch < NCH);
            if (req) begin
                t.rd = !we;
                t.d  = m_read(ch, rg);
                sb_q.push_back(t);
            end
            for (int c = 0; c < NCH; c++) begin
                hit_c    = wr && (ch == c);
                en_after = (hit_c && rg == 0 && sel[0]) ? dat[0] : m_en[c];
                clr      = hit_c && rg == 3 && sel[0] && dat[0];
                if (m_en[c] && en_after && m_cnt[c] == m_pa[c]) begin
                    m_cnt[c] = 0; m_pa[c] = m_per[c]; m_da[c] = m_duty[c]; m_wrap[c] = 1;
                end else if (m_en[c] && en_after) begin
                    m_cnt[c] = m_cnt[c] + 1;
                    if (clr) m_wrap[c] = 0;
                end else begin
                    m_cnt[c] = 0; m_pa[c] = m_per[c]; m_da[c] = m_duty[c];
                    if (clr) m_wrap[c] = 0;
                end
            end
            if (wr) begin
                case (rg)
                    0: begin
                        v = merge({29'd0, m_ie[ch], m_pol[ch], m_en[ch]}, dat, sel);
                        m_en[ch] = v[0]; m_pol[ch] = v[1]; m_ie[ch] = v[2];
                    end
                    1: m_per[ch]  = merge(m_per[ch], dat, sel) & 32'hFFFF;
                    2: m_duty[ch] = merge(m_duty[ch], dat, sel) & 32'hFFFF;
                    default: ;
                endcase
            end
            m_ack = req;
        end
    endtask

    always @(posedge clk) model_step();

    // Monitor: outputs against the model, read data against the scoreboard
    always @(negedge clk) begin
        if (mon_on) begin
            chk("ack", wbs_ack_o, m_ack);
            chk("pwm_o", pwm_o, e_pwm);
            chk("pwm_oeb", pwm_oeb, e_oeb);
            chk("irq_o", irq_o, e_irq);
            if (wbs_ack_o) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_unexpected_ack actual=1 required=0 t=%0t", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.rd) chk("rdata", wbs_dat_o, mon_e.d);
                end
            end else begin
                chk("dat_idle", wbs_dat_o, 32'h0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit samp[64];

    task automatic wb(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] s,
                      input bit exp_ack, output logic [31:0] rd);
        int n;
        bit got;
        @(negedge clk);
        adr = a; we = w; dat = d; sel = s; cyc = 1; stb = 1;
        got = 0; n = 0; rd = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (wbs_ack_o) begin got = 1; n = k; rd = wbs_dat_o; break; end
        end
        cyc = 0; stb = 0; we = 0;
        if (exp_ack) chk("ack_latency", n, 1);
        else chk("miss_no_ack", got, 0);
    endtask

    task automatic wr32(input int ch, input int rg, input logic [31:0] d);
        logic [31:0] r;
        wb(32'h3000_0000 + ch * 16 + rg * 4, 1, d, 4'hF, 1, r);
    endtask

    task automatic rd32(input int ch, input int rg, output logic [31:0] r);
        wb(32'h3000_0000 + ch * 16 + rg * 4, 0, 32'h0, 4'hF, 1, r);
    endtask

    task automatic wait_rise(input int ch, output bit ok);
        bit prev;
        ok = 0; prev = pwm_o[ch];
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!prev && pwm_o[ch]) begin ok = 1; break; end
            prev = pwm_o[ch];
        end
    endtask

    task automatic wait_irq_rise(output bit ok);
        bit prev;
        ok = 0; prev = irq_o;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!prev && irq_o) begin ok = 1; break; end
            prev = irq_o;
        end
    endtask

    task automatic capture(input int ch, input int n);
        for (int k = 0; k < n; k++) begin @(negedge clk); samp[k] = pwm_o[ch]; end
    endtask

    task automatic run_len(input int start, input bit val, output int len, output int nxt);
        len = 0; nxt = start;
        while (nxt < 64 && samp[nxt] == val) begin len++; nxt++; end
    endtask

    function automatic int ones(input int n);
        int s = 0;
        for (int k = 0; k < n; k++) s += int'(samp[k]);
        return s;
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a, d;
        logic [3:0]  s;
        bit ok, w;
        int l, nx, c, rg;

        // Reset
        @(posedge clk);
        @(negedge clk);
        mon_on = 1;
        repeat (2) @(negedge clk);
        chk("rst_oeb", pwm_oeb, 8'hFF);
        chk("rst_pwm", pwm_o, 8'h00);
        chk("rst_irq", irq_o, 0);
        chk("rst_ack", wbs_ack_o, 0);
        rst_n = 1;
        rd32(0, 0, r); chk("rst_ctrl0", r, 0);
        rd32(0, 1, r); chk("rst_period0", r, 0);
        rd32(0, 2, r); chk("rst_duty0", r, 0);

        // ch0 basic waveform
        wr32(0, 1, 9); wr32(0, 2, 3); wr32(0, 0, 1);
        wait_rise(0, ok); chk("ch0_rise", ok, 1);
        capture(0, 20);
        run_len(0, 1, l, nx); chk("ch0_high", l + 1, 3);
        run_len(nx, 0, l, nx); chk("ch0_low", l, 7);
        chk("ch0_oeb", pwm_oeb[0], 0);

        // ch1 duty change mid-period takes effect at the wrap
        wr32(1, 1, 9); wr32(1, 2, 3); wr32(1, 0, 1);
        wait_rise(1, ok); chk("ch1_rise", ok, 1);
        fork
            capture(1, 30);
            wr32(1, 2, 7);
        join
        run_len(0, 1, l, nx); chk("ch1_high_old", l + 1, 3);
        run_len(nx, 0, l, nx); chk("ch1_low_old", l, 7);
        run_len(nx, 1, l, nx); chk("ch1_high_new", l, 7);
        run_len(nx, 0, l, nx); chk("ch1_low_new", l, 3);

        // ch2 duty extremes and polarity
        wr32(2, 1, 9); wr32(2, 2, 0); wr32(2, 0, 1);
        repeat (12) @(negedge clk); capture(2, 20); chk("ch2_duty0_low", ones(20), 0);
        wr32(2, 2, 20);
        repeat (12) @(negedge clk); capture(2, 20); chk("ch2_duty20_high", ones(20), 20);
        wr32(2, 0, 3);
        repeat (12) @(negedge clk); capture(2, 20); chk("ch2_pol_low", ones(20), 0);
        wr32(2, 2, 0);
        repeat (12) @(negedge clk); capture(2, 20); chk("ch2_pol_high", ones(20), 20);
        wr32(2, 0, 2);
        repeat (3) @(negedge clk);
        chk("ch2_idle_pwm", pwm_o[2], 1);
        chk("ch2_idle_oeb", pwm_oeb[2], 1);

        // ch3 interrupt, clear, and clear coincident with a wrap
        wr32(3, 1, 4); wr32(3, 0, 5);
        wait_irq_rise(ok); chk("irq_rise", ok, 1);
        wr32(3, 3, 1);
        @(negedge clk); chk("irq_cleared", irq_o, 0);
        wait_irq_rise(ok); chk("irq_rise2", ok, 1);
        repeat (2) @(negedge clk);
        wr32(3, 3, 1);
        rd32(3, 3, r); chk("wrap_set_wins", r[0], 1);
        chk("irq_kept", irq_o, 1);

        // byte enables, unmapped channel, address miss
        wr32(4, 1, 32'h1234);
        wb(32'h3000_0044, 1, 32'hFFFF_FFFF, 4'b0001, 1, r);
        rd32(4, 1, r); chk("sel_merge", r, 32'h12FF);
        wb(32'h3000_0200, 0, 32'h0, 4'hF, 1, r); chk("unmapped_rd", r, 0);
        wb(32'h3000_1000, 0, 32'h0, 4'hF, 0, r);

        // randomized traffic, model checks every cycle
        for (int it = 0; it < 300; it++) begin
            if (it == 150) begin
                @(negedge clk); rst_n = 0;
                repeat (3) @(negedge clk); rst_n = 1;
            end
            c  = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 9));
            rg = int'($urandom_range(0, 3));
            a  = 32'h3000_0000 | (c << 4) | (rg << 2);
            w  = $urandom_range(0, 1) == 1;
            case (rg)
                0: d = $urandom_range(0, 7);
                1, 2: d = $urandom_range(0, 12);
                default: d = $urandom_range(0, 1);
            endcase
            if ($urandom_range(0, 9) == 0) d = $urandom;
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            wb(a, w, d, s, 1, r);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_pwm_bank.md
Name: wb_pwm_bank

Overview:
- Parametrised multi-channel PWM peripheral with a Wishbone slave. It is instantiated inside the user project wrapper.
- Each channel drives one user IO pad, and its output enable is driven as well.
- Each channel has an independent period, duty and polarity. Period and duty are double-buffered and update glitch-free at the period boundary.
- A single maskable interrupt summarises the per-channel period-wrap events.

Parameters:
- CHANNELS, 8, number of PWM channels (1..16).
- CNT_W, 16, counter, period and duty width in bits (2..32).
- BASE_ADDR, 32'h3000_0000, Wishbone base address. The block decodes wbs_adr_i[31:12] == BASE_ADDR[31:12].

Ports:
- wb_clk_i  in  1  Clock, shared by the Wishbone bus and the PWM logic.
- wb_rst_ni  in  1  Reset, synchronous, active-low.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  Write enable.
- wbs_sel_i  in  4  Byte enables.
- wbs_adr_i  in  32  Byte address.
- wbs_dat_i  in  32  Write data.
- wbs_ack_o  out  1  Acknowledge.
- wbs_dat_o  out  32  Read data.
- pwm_o  out  CHANNELS  PWM outputs, to io_out.
- pwm_oeb  out  CHANNELS  Active-low output enable, to io_oeb.
- irq_o  out  1  Interrupt, to one user_irq bit.

Behaviour:
- Reset (wb_rst_ni=0 at a clock edge):
  - All registers, counters and shadow registers go to 0.
  - pwm_o=0, pwm_oeb=all 1, wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
  - Reset asserted mid-period aborts immediately; no wrap flag is set.
- Register map: channel n sits at offset n*0x10. Registers are 32-bit, with fields zero-extended on read.
  - +0x0 CTRL: bit0 EN, bit1 POL (invert), bit2 IRQ_EN.
  - +0x4 PERIOD: CNT_W bits.
  - +0x8 DUTY: CNT_W bits.
  - +0xC STATUS: bit0 WRAP, W1C. The counter value is readable at bits [CNT_W+15:16] when CNT_W<=16; otherwise those bits read 0.
  - Offsets beyond channel CHANNELS-1 inside the 4 KB window: writes are ignored, reads return 0, ack is still given.
- Wishbone handshake:
  - A request is cyc&stb&decode-hit with ack currently 0.
  - wbs_ack_o is asserted the cycle after the request, for exactly one cycle.
  - Back-to-back requests are therefore acked every other cycle.
  - Writes commit on the edge that raises ack. wbs_sel_i masks writes per byte.
  - wbs_dat_o is registered and valid while ack=1; it is 0 otherwise.
  - An address miss gives no ack.
- Shadowing:
  - Programmed PERIOD and DUTY are copied to the active registers at each wrap.
  - While EN=0 the copy happens every cycle, so the programmed values are active immediately.
- Counter, per channel:
  - EN=0: the counter is held at 0.
  - EN=1: the counter increments by 1 per cycle.
  - When counter == active PERIOD, it wraps to 0 on the next edge. On that same edge the shadows load and WRAP is set.
  - Period length is PERIOD+1 cycles. PERIOD=0 gives a wrap every cycle.
  - An EN 0->1 write means the counter counts from 0 starting on the next edge.
- Output, per channel:
  - raw = (counter < active DUTY). DUTY=0 gives constant low; DUTY > PERIOD gives constant high.
  - pwm_o is registered as raw XOR POL, giving 1 cycle latency from the counter.
  - EN=0: pwm_o = POL (idle level) and pwm_oeb=1. EN=1: pwm_oeb=0 (registered).
- WRAP clearing: a W1C write of WRAP in the same cycle as a new wrap leaves WRAP=1 (set wins).
- irq_o is registered: OR over channels of (WRAP & IRQ_EN). It drops the cycle after the last qualifying WRAP is cleared.
- Writing CTRL.EN=0 mid-period stops the counter at once; WRAP is not set.

Test Plan:
- Reset, then read ch0 CTRL, PERIOD and DUTY -> all 0. Outputs are pwm_oeb=8'hFF, pwm_o=0, irq_o=0. Each access is acked exactly one cycle after stb.
- ch0: PERIOD=9, DUTY=3, EN=1 -> pwm_o[0] high for 3 cycles and low for 7, period 10. pwm_oeb[0]=0.
- ch1 running with PERIOD=9, DUTY=3; write DUTY=7 mid-period -> the current period keeps a high time of 3. The next period has high time 7, and the change occurs exactly at the wrap.
- ch2: DUTY=0, then DUTY=20 with PERIOD=9 -> constant low, then constant high. Setting POL=1 inverts both. Writing EN=0 -> pwm_o[2]=POL and pwm_oeb[2]=1.
- ch3: IRQ_EN=1, PERIOD=4 -> irq_o rises 1 cycle after the first wrap. Write STATUS=1 on a non-wrap cycle -> irq_o falls. A W1C write coincident with a wrap -> WRAP stays 1.
- Write with wbs_sel_i=4'b0001 and data 32'hFFFF_FFFF to PERIOD holding 0x1234 -> reads back 0x12FF. A read at offset 0x200 (unmapped channel) -> acked, data 0. Address 0x3000_1000 -> no ack.
